// File: rtl/mem_arbiter.sv
// mem_arbiter: data-priority arbiter sharing one memory port (mem_*) between fetch (if_*) and data (d_*) requesters, with stall, mem_ack timeout and sticky err
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        mem_req,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;
  state_t state;
  logic [7:0] wcnt;
  logic [31:0] rd;
  logic fin;
  always_comb begin
    fin = mem_ack || wcnt + 8'd1 == 8'(TIMEOUT);
    rd = mem_ack ? mem_rdata : 32'hDEADBEEF;
  end
  assign stall = (d_req & ~d_valid) | (if_req & ~if_valid);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wcnt <= '0;
      mem_req <= 1'b0;
      mem_we <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_rdata <= '0;
      d_rdata <= '0;
      if_valid <= 1'b0;
      d_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (d_req || if_req) begin
            state <= d_req ? BUSY_D : BUSY_I;
            mem_req <= 1'b1;
            mem_we <= d_req ? d_we : 4'h0;
            mem_addr <= d_req ? d_addr : if_addr;
            mem_wdata <= d_req ? d_wdata : 32'h0;
            wcnt <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (fin) begin
            state <= DONE;
            mem_req <= 1'b0;
            err <= err | ~mem_ack;
            if_valid <= state == BUSY_I;
            d_valid <= state == BUSY_D;
            if (state == BUSY_I) if_rdata <= rd;
            if (state == BUSY_D && mem_we == 4'h0) d_rdata <= rd;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, directed corner sequences and random traffic against a cycle-timeline reference model of mem_arbiter
module tb_mem_arbiter;
  localparam int TO = 255;
  localparam logic [31:0] DEAD = 32'hDEADBEEF;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic if_valid;
  logic d_req = 1'b0;
  logic [3:0] d_we = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic d_valid;
  logic mem_req;
  logic [3:0] mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic mem_ack = 1'b0;
  logic stall;
  logic err;
  always #5 clk = ~clk;
  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .err(err)
  );
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int own = 0;
  logic [3:0] o_we = '0;
  logic [31:0] o_addr = '0;
  logic [31:0] o_wdata = '0;
  int bcnt = 0;
  int dly = 0;
  int idle_from = 0;
  int vcyc = -10;
  int vown = 0;
  logic [31:0] x_if = '0;
  logic [31:0] x_d = '0;
  logic x_err = 1'b0;
  bit resp_en = 1'b1;
  bit rnd = 1'b0;
  bit spur = 1'b0;
  int fix_dly = 0;
  logic [31:0] fix_rd = '0;
  logic [3:0] seen_we = '0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask
  task automatic complete(input logic [31:0] v, input bit to);
    if (own == 1) x_if = v;
    else if (o_we == 4'h0) x_d = v;
    x_err = x_err | to;
    vown = own;
    vcyc = cyc + 1;
    idle_from = cyc + 2;
    own = 0;
  endtask
  task automatic cycle();
    bit ev_i;
    bit ev_d;
    if (rst) begin
      own = 0;
      x_if = '0;
      x_d = '0;
      x_err = 1'b0;
      idle_from = 0;
      vown = 0;
    end else if (own != 0) begin
      if (mem_ack) complete(mem_rdata, 1'b0);
      else begin
        bcnt++;
        if (bcnt == TO) complete(DEAD, 1'b1);
      end
    end else if (cyc >= idle_from && (d_req || if_req)) begin
      own = d_req ? 2 : 1;
      o_we = d_req ? d_we : 4'h0;
      o_addr = d_req ? d_addr : if_addr;
      o_wdata = d_wdata;
      bcnt = 0;
      dly = rnd ? int'($urandom_range(0, 4)) : fix_dly;
    end
    @(negedge clk);
    cyc++;
    ev_i = vcyc == cyc && vown == 1;
    ev_d = vcyc == cyc && vown == 2;
    chk("mem_req", mem_req, own != 0);
    if (own != 0) begin
      chk("mem_addr", mem_addr, o_addr);
      chk("mem_we", mem_we, o_we);
      if (own == 2) chk("mem_wdata", mem_wdata, o_wdata);
      seen_we = mem_we;
    end
    chk("if_valid", if_valid, ev_i);
    chk("d_valid", d_valid, ev_d);
    chk("if_rdata", if_rdata, x_if);
    chk("d_rdata", d_rdata, x_d);
    chk("err", err, x_err);
    chk("stall", stall, (d_req & ~ev_d) | (if_req & ~ev_i));
    mem_ack = !rst && (own != 0 ? resp_en && bcnt >= dly : spur && $urandom_range(0, 1) == 1);
    mem_rdata = rnd ? $urandom : fix_rd;
  endtask
  task automatic wait_valid(input bit isd, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(isd ? d_valid : if_valid) && n < 400);
    chk("valid_seen", isd ? d_valid : if_valid, 1'b1);
  endtask
  typedef struct {
    bit isd;
    logic [3:0] we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int dly;
    logic [3:0] x_we;
    logic [31:0] x_rd;
    int x_wait;
  } vec_t;
  vec_t tv[7];
  logic [3:0] wes[4];
  logic [31:0] addrs[$];
  initial begin
    int n;
    bit gotd;
    bit goti;
    bit prev;
    tv[0] = '{1'b0, 4'h0, 32'h100, 32'h0,       32'h3C011234, 0, 4'h0, 32'h3C011234, 2};
    tv[1] = '{1'b1, 4'h0, 32'h200, 32'h0,       32'h11112222, 2, 4'h0, 32'h11112222, 4};
    tv[2] = '{1'b1, 4'h1, 32'h44,  32'hAB,      32'h55555555, 1, 4'h1, 32'h11112222, 3};
    tv[3] = '{1'b1, 4'h3, 32'h48,  32'h1234,    32'h0,        0, 4'h3, 32'h11112222, 2};
    tv[4] = '{1'b1, 4'hF, 32'h4C,  32'hCAFEF00D,32'h77777777, 3, 4'hF, 32'h11112222, 5};
    tv[5] = '{1'b0, 4'h0, 32'h104, 32'h0,       32'h8C220004, 1, 4'h0, 32'h8C220004, 3};
    tv[6] = '{1'b1, 4'h0, 32'h208, 32'h0,       32'h0,        0, 4'h0, 32'h0,        2};
    wes = '{4'h0, 4'h1, 4'h3, 4'hF};
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    foreach (tv[i]) begin
      if (tv[i].isd) begin
        d_req = 1'b1;
        d_we = tv[i].we;
        d_addr = tv[i].addr;
        d_wdata = tv[i].wdata;
      end else begin
        if_req = 1'b1;
        if_addr = tv[i].addr;
      end
      fix_dly = tv[i].dly;
      fix_rd = tv[i].rdata;
      wait_valid(tv[i].isd, n);
      chk("tv_wait", n, tv[i].x_wait);
      chk("tv_we", seen_we, tv[i].x_we);
      chk("tv_rdata", tv[i].isd ? d_rdata : if_rdata, tv[i].x_rd);
      d_req = 1'b0;
      if_req = 1'b0;
      cycle();
      cycle();
    end
    fix_dly = 1;
    fix_rd = 32'h0BADF00D;
    d_req = 1'b1;
    d_we = 4'h0;
    d_addr = 32'h200;
    if_req = 1'b1;
    if_addr = 32'h300;
    gotd = 1'b0;
    goti = 1'b0;
    prev = 1'b0;
    addrs.delete();
    for (int k = 0; k < 40 && !goti; k++) begin
      cycle();
      if (mem_req && !prev) addrs.push_back(mem_addr);
      prev = mem_req;
      if (d_valid) begin
        gotd = 1'b1;
        d_req = 1'b0;
      end
      if (if_valid) begin
        goti = 1'b1;
        chk("coll_d_first", gotd, 1'b1);
      end
      chk("coll_stall", stall, !goti);
    end
    if_req = 1'b0;
    chk("coll_grants", addrs.size(), 2);
    if (addrs.size() == 2) begin
      chk("coll_addr0", addrs[0], 32'h200);
      chk("coll_addr1", addrs[1], 32'h300);
    end
    fix_dly = 0;
    fix_rd = 32'h13579BDF;
    if_req = 1'b1;
    if_addr = 32'h400;
    wait_valid(1'b0, n);
    cycle();
    if_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("no_regrant", mem_req, 1'b0);
    end
    spur = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("spur_valid", if_valid | d_valid, 1'b0);
    end
    spur = 1'b0;
    resp_en = 1'b0;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) begin
        d_req = 1'b1;
        d_we = 4'h0;
        d_addr = 32'h300;
      end else begin
        if_req = 1'b1;
        if_addr = 32'h310;
      end
      wait_valid(t == 0, n);
      chk("to_wait", n, TO + 1);
      chk("to_rdata", t == 0 ? d_rdata : if_rdata, DEAD);
      chk("to_err", err, 1'b1);
      d_req = 1'b0;
      if_req = 1'b0;
      cycle();
      cycle();
    end
    resp_en = 1'b1;
    rnd = 1'b1;
    spur = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      cycle();
      if (d_valid || !d_req) begin
        d_req = $urandom_range(0, 2) == 0;
        if (d_req) begin
          d_we = wes[$urandom_range(0, 3)];
          d_addr = $urandom;
          d_wdata = $urandom;
        end
      end
      if (if_valid || !if_req) begin
        if_req = $urandom_range(0, 2) == 0;
        if (if_req) if_addr = $urandom;
      end
    end
    d_req = 1'b0;
    if_req = 1'b0;
    rnd = 1'b0;
    spur = 1'b0;
    for (int k = 0; k < 8; k++) cycle();
    chk("err_sticky", err, 1'b1);
    resp_en = 1'b0;
    if_req = 1'b1;
    if_addr = 32'h500;
    for (int k = 0; k < 3; k++) cycle();
    chk("rst_pre_busy", mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 4'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_valids", {if_valid, d_valid}, 2'b00);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_err", err, 1'b0);
    if_req = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    resp_en = 1'b1;
    fix_dly = 0;
    fix_rd = 32'h12345678;
    if_req = 1'b1;
    if_addr = 32'h600;
    wait_valid(1'b0, n);
    chk("post_rst_wait", n, 2);
    chk("post_rst_rdata", if_rdata, 32'h12345678);
    if_req = 1'b0;
    cycle();
    cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide clk, input, 1, system clock; all state changes on rising edge.
REQ-002 SHALL provide rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL provide if_req (in, 1), instruction-fetch request.
REQ-004 SHALL provide if_addr (in, 32), fetch address.
REQ-005 SHALL provide if_rdata (out, 32), fetched word.
REQ-006 SHALL provide if_valid (out, 1), one-cycle fetch-complete pulse.
REQ-007 SHALL provide d_req (in, 1), data-access request.
REQ-008 SHALL provide d_we (in, 4), byte write mask: 0000 load; 0001 SB; 0011 SH; 1111 SW.
REQ-009 SHALL provide d_addr (in, 32) and d_wdata (in, 32).
REQ-010 SHALL provide d_rdata (out, 32), load word.
REQ-011 SHALL provide d_valid (out, 1), one-cycle data-complete pulse for loads and stores.
REQ-012 SHALL provide mem_req (out, 1), mem_we (out, 4), mem_addr (out, 32) and mem_wdata (out, 32), the shared memory port.
REQ-013 SHALL provide mem_rdata (in, 32) and mem_ack (in, 1), memory read data and one-cycle completion strobe.
REQ-014 SHALL provide stall (out, 1), pipeline hold, and err (out, 1), sticky timeout flag.
REQ-015 SHALL provide parameter TIMEOUT, default 255, the maximum number of cycles to wait for mem_ack.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY_I, BUSY_D and DONE.
REQ-017 In IDLE, an eligible d_req SHALL move the FSM to BUSY_D; otherwise an eligible if_req SHALL move it to BUSY_I. Data has fixed priority.
REQ-018 On the grant edge, the arbiter SHALL latch the winner's address, write mask and write data (write mask 0000 for fetches). mem_* outputs SHALL drive only these latched values.
REQ-019 mem_req SHALL equal 1 exactly while in BUSY_I or BUSY_D, and mem_we/mem_addr/mem_wdata SHALL stay stable for that whole interval.
REQ-020 mem_ack sampled high in BUSY_x SHALL capture mem_rdata into the owner's rdata register (loads and fetches only), pulse the owner's *_valid in the next cycle, and move the FSM to DONE.
REQ-021 DONE SHALL last exactly one cycle and return to IDLE. Minimum request-to-valid latency is 3 cycles when mem_ack arrives in the first BUSY cycle.
REQ-022 A store completion SHALL pulse d_valid and leave d_rdata unchanged.
REQ-023 Requesters SHALL hold their req and payload until *_valid. A req still high during its own valid cycle SHALL NOT be treated as a new request. A fresh request is eligible from the IDLE cycle onward.
REQ-024 mem_ack in IDLE or DONE SHALL be ignored.
REQ-025 An 8-bit wait counter SHALL clear on grant and increment each BUSY cycle without mem_ack.
REQ-026 When the wait counter reaches TIMEOUT, the arbiter SHALL set err=1 (sticky), pulse the owner's *_valid with rdata forced to 32'hDEADBEEF (loads and fetches), and go to DONE.
REQ-027 stall SHALL equal (d_req & ~d_valid) | (if_req & ~if_valid), combinationally.
REQ-028 Simultaneous if_req and d_req in IDLE SHALL serve data first, then fetch, with no idle cycles beyond DONE.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_valid=0, d_valid=0, if_rdata=0, d_rdata=0, err=0 and wait counter=0.
REQ-030 A reset mid-transaction SHALL abandon the transaction with no valid pulse. The first post-reset grant SHALL occur no earlier than the first rising edge after rst falls.

Verification
REQ-031 Fetch: if_req=1, if_addr=0x100; mem_ack one cycle after mem_req rises with mem_rdata=0x3C011234 -> mem_we=0000, mem_addr=0x100, if_valid pulses once, if_rdata=0x3C011234.
REQ-032 Collision: if_req and d_req (load, 0x200) rise together -> mem_addr=0x200 first, d_valid, then mem_addr for the fetch, if_valid. No overlap; stall=1 until both valids are seen.
REQ-033 Store SB: d_we=0001, d_addr=0x44, d_wdata=0xAB -> mem_we=0001, mem_wdata=0xAB held until ack, d_valid pulses, d_rdata unchanged.
REQ-034 Timeout: d_req load with mem_ack never asserted -> after 255 BUSY cycles d_valid=1, d_rdata=0xDEADBEEF, err=1 and remains 1.
REQ-035 Reset mid-op: assert rst in BUSY_I -> mem_req falls the same cycle, no if_valid, all outputs 0. A request after release is served normally.
REQ-036 Spurious ack: mem_ack=1 in IDLE -> no valid pulse and no state change.
